alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 4, the number of consecutive req0 grants after which a waiting req1 is forced (fixed-priority mode only).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester i has an operation pending.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  32  operands of requester i.
REQ-006 req0_aluc / req1_aluc  input  4  ALU opcode of requester i (0000 ADD through 1101 LUI).
REQ-007 req0_ready / req1_ready  output  1  one-cycle grant pulse; operands are captured in this cycle.
REQ-008 alu_a, alu_b  output  32  operands driven to the shared combinational ALU.
REQ-009 alu_aluc  output  4  opcode driven to the ALU.
REQ-010 alu_y  input  32  ALU result.
REQ-011 alu_zero, alu_carry, alu_negative, alu_overflow  input  1 each  ALU flags.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_id  output  1  requester that owns the response.
REQ-014 rsp_y  output  32  registered result.
REQ-015 rsp_zero, rsp_carry, rsp_negative, rsp_overflow  output  1 each  registered flags.
REQ-016 rsp_err  output  1  captured opcode was 1110 or 1111.
REQ-017 rsp_ready  input  1  consumer accepts the response.

Function
REQ-018 The FSM SHALL have three states, IDLE, EXEC and RESP, with these transitions: IDLE->EXEC on grant; EXEC->RESP unconditionally; RESP->IDLE when rsp_ready=1.
REQ-019 In IDLE with at least one valid, the block SHALL grant exactly one requester, pulse its ready for one cycle, and latch its a, b, aluc and id.
REQ-020 ready SHALL be 0 in EXEC and RESP regardless of valid; the next grant SHALL occur no earlier than the cycle after RESP exits.
REQ-021 alu_a, alu_b and alu_aluc SHALL drive the latched values in EXEC and RESP, and 0 in IDLE.
REQ-022 At the end of EXEC, the block SHALL register alu_y and the four flags into the rsp_* outputs.
REQ-023 If the latched aluc is 1110 or 1111, rsp_y and all rsp flags SHALL be 0 and rsp_err SHALL be 1; otherwise rsp_err SHALL be 0.
REQ-024 Latency SHALL be: grant in cycle T, EXEC in T+1, rsp_valid=1 from T+2; the minimum issue interval is 3 cycles.
REQ-025 rsp_* outputs SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-026 rsp_valid SHALL be 1 only in RESP.
REQ-027 A valid deasserted before its grant SHALL receive no grant and no response.
REQ-028 With only one valid in IDLE, that requester SHALL be granted regardless of arbitration state.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL enter IDLE and drive all outputs to 0.
REQ-030 Reset SHALL clear the round-robin pointer to 0 and the starvation counter to 0.
REQ-031 Reset during EXEC or RESP SHALL discard the transaction; no rsp_valid SHALL follow.

Configuration
REQ-032 The macro ALU_ARBITER_RR_EN SHALL select the arbitration mode.
REQ-033 With ALU_ARBITER_RR_EN defined, simultaneous valids SHALL be granted round-robin: the pointer favours req0 after reset and toggles to favour the other requester after each grant; STARVE_LIMIT SHALL be ignored.
REQ-034 Without ALU_ARBITER_RR_EN, req0 SHALL win simultaneous valids, except that req1 SHALL be forced after STARVE_LIMIT consecutive req0 grants during which req1_valid was 1.
REQ-035 In fixed-priority mode, the starvation counter SHALL clear on any req1 grant and on any grant while req1_valid=0.

Verification
REQ-036 rst held 1 for 2 cycles, then released -> all outputs 0, state IDLE.
REQ-037 req0 ADD a=0x7FFFFFFF b=1, rsp_ready=1 -> req0_ready at T; at T+2 rsp_valid=1, rsp_id=0, rsp_y=0x80000000, rsp_negative=1, rsp_overflow=1.
REQ-038 Both valid continuously, RR build -> grant order 0,1,0,1; fixed build with STARVE_LIMIT=4 -> 0,0,0,0,1,0.
REQ-039 req1 aluc=1111 -> rsp_err=1, rsp_y=0, rsp_id=1.
REQ-040 rsp_ready held 0 for 5 cycles with a SUBU 3-5 response -> rsp_y=0xFFFFFFFE held stable, no new grant; released -> IDLE the next cycle.
REQ-041 rst=1 during EXEC -> no rsp_valid follows; after release, a pending req1 is granted normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: grant, execute, hold response.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority with starvation guard.
module alu_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_aluc,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_aluc,
   output logic        req1_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_aluc,
   input  logic [31:0] alu_y,
   input  logic        alu_zero,
   input  logic        alu_carry,
   input  logic        alu_negative,
   input  logic        alu_overflow,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_y,
   output logic        rsp_zero,
   output logic        rsp_carry,
   output logic        rsp_negative,
   output logic        rsp_overflow,
   output logic        rsp_err,
   input  logic        rsp_ready
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nx;
   logic [31:0] lat_a, lat_b;
   logic [3:0]  lat_aluc;
   logic        lat_id;
   logic        pick1;
   logic        lat_err;

`ifdef ALU_ARBITER_RR_EN
   logic rr_ptr;
   always_comb pick1 = req1_valid && (!req0_valid || rr_ptr);
`else
   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] starve_cnt;
   always_comb pick1 = req1_valid && (!req0_valid || (starve_cnt >= CW'(STARVE_LIMIT)));
`endif

   always_comb lat_err = (lat_aluc[3:1] == 3'b111);

   always_comb begin
      state_nx   = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: if (!rst && (req0_valid || req1_valid)) begin
            req1_ready = pick1;
            req0_ready = !pick1;
            state_nx   = EXEC;
         end
         EXEC:    state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_aluc = '0;
      if (state != IDLE) begin
         alu_a    = lat_a;
         alu_b    = lat_b;
         alu_aluc = lat_aluc;
      end
   end

   always_comb rsp_valid = (state == RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         lat_a        <= '0;
         lat_b        <= '0;
         lat_aluc     <= '0;
         lat_id       <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_y        <= '0;
         rsp_zero     <= 1'b0;
         rsp_carry    <= 1'b0;
         rsp_negative <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_err      <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
         rr_ptr       <= 1'b0;
`else
         starve_cnt   <= '0;
`endif
      end else begin
         state <= state_nx;
         if (req0_ready || req1_ready) begin
            lat_a    <= req1_ready ? req1_a    : req0_a;
            lat_b    <= req1_ready ? req1_b    : req0_b;
            lat_aluc <= req1_ready ? req1_aluc : req0_aluc;
            lat_id   <= req1_ready;
`ifdef ALU_ARBITER_RR_EN
            rr_ptr   <= req0_ready;
`else
            // Only req0 wins taken while req1 was waiting count toward starvation.
            if (req1_ready || !req1_valid) starve_cnt <= '0;
            else                           starve_cnt <= starve_cnt + 1'b1;
`endif
         end
         if (state == EXEC) begin
            rsp_id       <= lat_id;
            rsp_err      <= lat_err;
            rsp_y        <= lat_err ? '0 : alu_y;
            rsp_zero     <= alu_zero     && !lat_err;
            rsp_carry    <= alu_carry    && !lat_err;
            rsp_negative <= alu_negative && !lat_err;
            rsp_overflow <= alu_overflow && !lat_err;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU stand-in answers the shared ALU port.
// Grant-order expectations follow ALU_ARBITER_RR_EN when defined.
module tb_alu_arbiter;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUBU = 4'b0001;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  req0_aluc = '0, req1_aluc = '0;
   logic        req0_ready, req1_ready;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [3:0]  alu_aluc;
   logic        alu_zero, alu_carry, alu_negative, alu_overflow;
   logic        rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_negative, rsp_overflow, rsp_err;
   logic [31:0] rsp_y;
   logic        rsp_ready = 1'b0;
   logic [32:0] sum;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc), .req1_ready(req1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_y(alu_y),
      .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_negative(rsp_negative), .rsp_overflow(rsp_overflow),
      .rsp_err(rsp_err), .rsp_ready(rsp_ready)
   );

   // Unknown opcodes return a loud nonzero result so error masking is visible.
   always_comb begin
      sum          = '0;
      alu_y        = '0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (alu_aluc)
         OP_ADD: begin
            sum          = {1'b0, alu_a} + {1'b0, alu_b};
            alu_y        = sum[31:0];
            alu_carry    = sum[32];
            alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
         end
         OP_SUBU: begin
            alu_y     = alu_a - alu_b;
            alu_carry = alu_a < alu_b;
         end
         default: begin
            alu_y        = 32'hDEADBEEF;
            alu_carry    = 1'b1;
            alu_overflow = 1'b1;
         end
      endcase
      alu_zero     = (alu_y == 32'd0);
      alu_negative = alu_y[31];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_handshake got %b want 000", {req0_ready, req1_ready, rsp_valid});
      end
      vectors++;
      if ({alu_a, alu_b, alu_aluc} !== 68'd0) begin
         miscompares++;
         $display("FAIL reset_alu_port got %h want 0", {alu_a, alu_b, alu_aluc});
      end
      vectors++;
      if ({rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_negative, rsp_overflow, rsp_err} !== 38'd0) begin
         miscompares++;
         $display("FAIL reset_rsp got %h want 0", {rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_negative, rsp_overflow, rsp_err});
      end
      cyc();
   endtask

   task automatic test_add();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h7FFFFFFF; req0_b = 32'd1; req0_aluc = OP_ADD;
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL add_grant got %b want 10", {req0_ready, req1_ready});
      end
      cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({alu_a, alu_b, alu_aluc} !== {32'h7FFFFFFF, 32'd1, OP_ADD}) begin
         miscompares++;
         $display("FAIL add_exec_operands got %h %h %h want 7fffffff 1 0", alu_a, alu_b, alu_aluc);
      end
      vectors++;
      if ({req0_ready, rsp_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL add_exec_quiet got %b want 00", {req0_ready, rsp_valid});
      end
      cyc();
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 32'h80000000}) begin
         miscompares++;
         $display("FAIL add_rsp got v=%b id=%b y=%h want v=1 id=0 y=80000000", rsp_valid, rsp_id, rsp_y);
      end
      vectors++;
      if ({rsp_zero, rsp_carry, rsp_negative, rsp_overflow, rsp_err} !== 5'b00110) begin
         miscompares++;
         $display("FAIL add_flags got %b want 00110", {rsp_zero, rsp_carry, rsp_negative, rsp_overflow, rsp_err});
      end
      cyc();
      @(negedge clk);
      vectors++;
      if ({rsp_valid, alu_a} !== 33'd0) begin
         miscompares++;
         $display("FAIL add_back_idle got v=%b alu_a=%h want 0 0", rsp_valid, alu_a);
      end
      cyc();
   endtask

   task automatic test_err();
      rsp_ready  = 1'b1;
      req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6; req1_aluc = 4'b1111;
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL err_grant got %b want 01", {req0_ready, req1_ready});
      end
      cyc();
      req1_valid = 1'b0;
      cyc();
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_y} !== {3'b111, 32'd0}) begin
         miscompares++;
         $display("FAIL err_rsp got v=%b id=%b err=%b y=%h want 1 1 1 0", rsp_valid, rsp_id, rsp_err, rsp_y);
      end
      vectors++;
      if ({rsp_zero, rsp_carry, rsp_negative, rsp_overflow} !== 4'b0000) begin
         miscompares++;
         $display("FAIL err_flags got %b want 0000", {rsp_zero, rsp_carry, rsp_negative, rsp_overflow});
      end
      cyc();
   endtask

   task automatic test_hold();
      rsp_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5; req0_aluc = OP_SUBU;
      @(negedge clk);
      vectors++;
      if (req0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_grant got %b want 1", req0_ready);
      end
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_aluc = OP_ADD;
      cyc();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {2'b10, 32'hFFFFFFFE, 1'b0}) begin
            miscompares++;
            $display("FAIL hold_rsp[%0d] got v=%b id=%b y=%h err=%b want 1 0 fffffffe 0", i, rsp_valid, rsp_id, rsp_y, rsp_err);
         end
         vectors++;
         if ({rsp_zero, rsp_carry, rsp_negative, rsp_overflow, req0_ready, req1_ready} !== 6'b011000) begin
            miscompares++;
            $display("FAIL hold_flags_ready[%0d] got %b want 011000", i,
                     {rsp_zero, rsp_carry, rsp_negative, rsp_overflow, req0_ready, req1_ready});
         end
         cyc();
         if (i == 2) req1_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({rsp_valid, req0_ready, req1_ready, alu_a} !== 35'd0) begin
            miscompares++;
            $display("FAIL hold_release[%0d] got v=%b r0=%b r1=%b alu_a=%h want all 0", i, rsp_valid, req0_ready, req1_ready, alu_a);
         end
         cyc();
      end
   endtask

   task automatic test_reset_exec();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_aluc = OP_ADD;
      @(negedge clk);
      vectors++;
      if (req0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstexec_grant got %b want 1", req0_ready);
      end
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_aluc = OP_SUBU;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, req0_ready, req1_ready, alu_a} !== {3'b001, 32'd0}) begin
         miscompares++;
         $display("FAIL rstexec_after got v=%b r0=%b r1=%b alu_a=%h want 0 0 1 0", rsp_valid, req0_ready, req1_ready, alu_a);
      end
      cyc();
      req1_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, alu_a} !== {1'b0, 32'd9}) begin
         miscompares++;
         $display("FAIL rstexec_exec got v=%b alu_a=%h want 0 9", rsp_valid, alu_a);
      end
      cyc();
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_y} !== {2'b11, 32'd5}) begin
         miscompares++;
         $display("FAIL rstexec_rsp got v=%b id=%b y=%h want 1 1 5", rsp_valid, rsp_id, rsp_y);
      end
      cyc();
   endtask

   task automatic test_arbitration();
      logic exp_seq [6];
      int   n = 0;
      int   last = 0;
`ifdef ALU_ARBITER_RR_EN
      exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_aluc = OP_ADD;
      req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_aluc = OP_SUBU;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clk);
         if (req0_ready && req1_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL arb_double_grant at cycle %0d got 11 want one-hot", c);
         end else if (req0_ready || req1_ready) begin
            vectors++;
            if (req1_ready !== exp_seq[n]) begin
               miscompares++;
               $display("FAIL arb_order[%0d] got id %b want %b", n, req1_ready, exp_seq[n]);
            end
            if (n > 0) begin
               vectors++;
               if (c - last != 3) begin
                  miscompares++;
                  $display("FAIL arb_interval[%0d] got %0d want 3", n, c - last);
               end
            end
            last = c;
            n++;
         end
         if (rsp_valid) begin
            vectors++;
            if (rsp_y !== (rsp_id ? 32'd7 : 32'd3)) begin
               miscompares++;
               $display("FAIL arb_rsp_y id=%b got %h want %h", rsp_id, rsp_y, rsp_id ? 32'd7 : 32'd3);
            end
         end
         cyc();
      end
      vectors++;
      if (n != 6) begin
         miscompares++;
         $display("FAIL arb_timeout got %0d grants want 6", n);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) cyc();
   endtask

   initial begin
      test_reset();
      test_add();
      test_err();
      test_hold();
      test_reset_exec();
      test_arbitration();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
